agc_muldiv_unit: RTL and testbench
==================================

Name: agc_muldiv_unit

Overview:
- Sequential multiply/divide engine downstream of the AGC control unit; executes the extracode MP and DV instructions.
- The control unit hands over A, L and the memory operand (G). The engine iterates one magnitude bit per clock and returns a double-precision product, or a quotient/remainder pair, for write-back to A and L.
- All words are 15-bit ones' complement: bit 14 is the sign, and a negative value is the bitwise inverse of its magnitude, so both +0 and -0 exist.

Parameters:
- WORD_W, 15, word width including sign; only 15 is verified.
- MAG_W, WORD_W-1, magnitude width; also the iteration count.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = MP, 1 = DV
- a_in  in  WORD_W  A register: MP multiplicand; DV dividend high word
- l_in  in  WORD_W  L register: DV dividend low word; ignored for MP
- b_in  in  WORD_W  memory operand (G): MP multiplier; DV divisor
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- res_hi  out  WORD_W  MP: product high word; DV: quotient (destined for A)
- res_lo  out  WORD_W  MP: product low word; DV: remainder (destined for L)
- ovf  out  1  DV overflow / divide-by-zero flag; always 0 for MP

Behaviour:
- Reset (reset_n low, asynchronous) drives state to IDLE and busy, done, ovf, res_hi, res_lo to 0. Reset mid-operation aborts the operation with no done pulse.
- States and transitions:
  - IDLE -> LOAD on start=1. op, a_in, l_in and b_in are registered on that edge; later input changes are ignored.
  - LOAD (1 cycle): form magnitudes and result sign; for DV, evaluate the overflow check.
  - ITER (MAG_W cycles, down-counter MAG_W-1..0): run the magnitude algorithm.
  - FIN (1 cycle): apply signs, register results, pulse done, return to IDLE.
- Latency is fixed: done goes high exactly MAG_W+2 = 16 rising edges after the accepting edge, for every op including DV overflow.
- start while busy or while done is high is ignored; a request is never queued.
- res_hi, res_lo and ovf update only in FIN and hold until the next FIN or reset.
- MP algorithm:
  - Unsigned shift-add of |a| x |b| giving a 2*MAG_W-bit magnitude P.
  - Result sign s = sign(a) XOR sign(b).
  - res_hi = P[27:14] with sign s; res_lo = P[13:0] with sign s. Both words always carry s, including a zero product, so -0 is possible.
- DV algorithm:
  - Dividend sign sd = sign(a_in), unless a_in is +0 or -0, in which case sd = sign(l_in).
  - Dividend magnitude D = {|a_in|, |l_in|}.
  - Restoring division, one quotient bit per ITER cycle.
  - Quotient sign = sd XOR sign(b); remainder sign = sd.
  - Zero quotient or zero remainder carries the computed sign.
- DV overflow: if |a_in| >= |b_in| (this includes |b_in| = 0), then ovf = 1, res_hi = max magnitude 0x3FFF with the quotient sign, and res_lo = a_in unchanged. ITER still runs its full count.
- Magnitude of a ones' complement word = the word if bit 14 is 0, otherwise its bitwise inverse, taking bits [13:0]. -0 has magnitude 0.

Decomposition:
- Shared package agc_pkg: WORD_W, MAG_W, OP_MP/OP_DV encodings, the state enum (IDLE, LOAD, ITER, FIN), and the 0x3FFF overflow constant. The package is reused by the control unit for op encoding.
- One combinational sub-module, agc_ones_comp: outputs magnitude and sign of a word, and can rebuild a word from a sign and magnitude. It is instantiated for a, l and b, and for both results.

Test Plan:
- MP, positive × positive: a=0x0003, b=0x0005, start -> done at edge 16; res_hi=0x0000, res_lo=0x000F, ovf=0.
- MP, negative × positive: a=0x7FFC (-3), b=0x0005 -> res_hi=0x7FFF (-0), res_lo=0x7FF0 (-15).
- MP, maximum magnitudes: a=0x3FFF, b=0x3FFF -> res_hi=0x3FFE, res_lo=0x0001.
- DV, positive then negative dividend:
  - a=0x0000, l=0x0064 (100), b=0x0007 -> res_hi=0x000E, res_lo=0x0002, ovf=0.
  - a=0x7FFF (-0), l=0x7F9B (-100), b=0x0007 -> res_hi=0x7FF1 (-14), res_lo=0x7FFD (-2).
- DV, overflow and divide-by-zero:
  - a=0x0005, l=0, b=0x0005 -> ovf=1, res_hi=0x3FFF, res_lo=0x0005, done still at edge 16.
  - b=0x0000 with a=0 -> ovf=1.
- Control behaviour:
  - Re-pulse start during ITER -> ignored, exactly one done.
  - Drop reset_n mid-ITER -> busy, done and outputs go 0 immediately with no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared AGC constants: word geometry, op encoding, engine states.
package agc_pkg;

  localparam int WORD_W = 15;
  localparam int MAG_W  = WORD_W - 1;
  localparam int CNT_W  = $clog2(MAG_W);

  typedef enum logic {
    OP_MP = 1'b0,
    OP_DV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    FIN
  } state_e;

  // Quotient magnitude reported when a divide overflows.
  localparam logic [MAG_W-1:0] DV_OVF_MAG = 14'h3FFF;

endpackage

// File: rtl/agc_muldiv_unit_if.sv
// Request/response bundle between the AGC control unit and the MP/DV engine.
interface agc_muldiv_unit_if;
  import agc_pkg::*;

  logic              start;
  logic              op;
  logic [WORD_W-1:0] a_in;
  logic [WORD_W-1:0] l_in;
  logic [WORD_W-1:0] b_in;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] res_hi;
  logic [WORD_W-1:0] res_lo;
  logic              ovf;

  modport master (
    output start, op, a_in, l_in, b_in,
    input  busy, done, res_hi, res_lo, ovf
  );

  modport slave (
    input  start, op, a_in, l_in, b_in,
    output busy, done, res_hi, res_lo, ovf
  );

endinterface

// File: rtl/agc_ones_comp.sv
// Ones' complement helper: splits a word into sign/magnitude and
// rebuilds a word from sign/magnitude.
module agc_ones_comp
  import agc_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [MAG_W-1:0]  mag,
  output logic              sign,
  input  logic              sign_in,
  input  logic [MAG_W-1:0]  mag_in,
  output logic [WORD_W-1:0] word_out
);

  // Negative words are the bitwise inverse of their magnitude, so -0 decodes to 0.
  always_comb begin
    sign     = word[WORD_W-1];
    mag      = sign ? ~word[MAG_W-1:0] : word[MAG_W-1:0];
    word_out = sign_in ? ~{1'b0, mag_in} : {1'b0, mag_in};
  end

endmodule

// File: rtl/agc_muldiv_unit.sv
// Sequential MP/DV engine: one magnitude bit per clock, fixed 16-edge latency.
module agc_muldiv_unit
  import agc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  agc_muldiv_unit_if.slave   bus
);

  state_e               state, state_next;
  op_e                  op_r;
  logic [WORD_W-1:0]    a_r, l_r, b_r;
  logic [CNT_W-1:0]     cnt;
  logic [2*MAG_W-1:0]   acc, acc_iter;
  logic                 ovf_pend;
  logic                 accept;

  logic                 busy_r, done_r, ovf_r;
  logic [WORD_W-1:0]    res_hi_r, res_lo_r;

  logic [MAG_W-1:0]     mag_a, mag_l, mag_b;
  logic                 sign_a, sign_l, sign_b;
  logic                 p_sign, sd, q_sign;

  logic [MAG_W:0]       mp_sum, dv_trial;
  logic [MAG_W-1:0]     dv_diff, dv_rem;
  logic                 dv_ge;

  logic                 hi_sign, lo_sign;
  logic [MAG_W-1:0]     hi_mag, lo_mag;
  logic [WORD_W-1:0]    hi_word, lo_built, lo_word;

  logic [WORD_W-1:0]    a_word_unused, l_word_unused, b_word_unused;
  logic [MAG_W-1:0]     hi_mag_unused, lo_mag_unused;
  logic                 hi_sign_unused, lo_sign_unused;

  agc_ones_comp u_oc_a (
    .word(a_r), .mag(mag_a), .sign(sign_a),
    .sign_in(1'b0), .mag_in('0), .word_out(a_word_unused)
  );

  agc_ones_comp u_oc_l (
    .word(l_r), .mag(mag_l), .sign(sign_l),
    .sign_in(1'b0), .mag_in('0), .word_out(l_word_unused)
  );

  agc_ones_comp u_oc_b (
    .word(b_r), .mag(mag_b), .sign(sign_b),
    .sign_in(1'b0), .mag_in('0), .word_out(b_word_unused)
  );

  agc_ones_comp u_oc_hi (
    .word('0), .mag(hi_mag_unused), .sign(hi_sign_unused),
    .sign_in(hi_sign), .mag_in(hi_mag), .word_out(hi_word)
  );

  agc_ones_comp u_oc_lo (
    .word('0), .mag(lo_mag_unused), .sign(lo_sign_unused),
    .sign_in(lo_sign), .mag_in(lo_mag), .word_out(lo_built)
  );

  // A request is only taken when fully idle, never while the done pulse is out.
  assign accept = (state == IDLE) && bus.start && !done_r;

  assign p_sign = sign_a ^ sign_b;
  assign sd     = (mag_a == '0) ? sign_l : sign_a;
  assign q_sign = sd ^ sign_b;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = ITER;
      ITER: if (cnt == '0) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the operands on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r <= OP_MP;
      a_r  <= '0;
      l_r  <= '0;
      b_r  <= '0;
    end else if (accept) begin
      op_r <= op_e'(bus.op);
      a_r  <= bus.a_in;
      l_r  <= bus.l_in;
      b_r  <= bus.b_in;
    end
  end

  // One iteration step. acc holds {high, low}: for MP the partial product with the
  // multiplier shifting out of the low half; for DV the partial remainder in the
  // high half and the dividend low bits shifting out while quotient bits shift in.
  always_comb begin
    mp_sum   = {1'b0, acc[2*MAG_W-1:MAG_W]} + (acc[0] ? {1'b0, mag_a} : '0);
    dv_trial = {acc[2*MAG_W-1:MAG_W], acc[MAG_W-1]};
    dv_ge    = dv_trial >= {1'b0, mag_b};
    dv_diff  = dv_trial[MAG_W-1:0] - mag_b;
    dv_rem   = dv_ge ? dv_diff : dv_trial[MAG_W-1:0];
    if (op_r == OP_DV) acc_iter = {dv_rem, acc[MAG_W-2:0], dv_ge};
    else               acc_iter = {mp_sum, acc[MAG_W-1:1]};
  end

  // Datapath: seed in LOAD, iterate MAG_W times in ITER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          acc      <= (op_r == OP_DV) ? {mag_a, mag_l} : {{MAG_W{1'b0}}, mag_b};
          cnt      <= CNT_W'(MAG_W - 1);
          ovf_pend <= (mag_a >= mag_b);
        end
        ITER: begin
          acc <= acc_iter;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Select sign/magnitude of each result word for rebuilding.
  always_comb begin
    hi_sign = p_sign;
    hi_mag  = acc[2*MAG_W-1:MAG_W];
    lo_sign = p_sign;
    lo_mag  = acc[MAG_W-1:0];
    lo_word = lo_built;
    if (op_r == OP_DV) begin
      hi_sign = q_sign;
      hi_mag  = ovf_pend ? DV_OVF_MAG : acc[MAG_W-1:0];
      lo_sign = sd;
      lo_mag  = acc[2*MAG_W-1:MAG_W];
      if (ovf_pend) lo_word = a_r;
    end
  end

  // Status and result registers; results change only on the FIN edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      res_hi_r <= '0;
      res_lo_r <= '0;
    end else begin
      done_r <= (state == FIN);
      if (accept)             busy_r <= 1'b1;
      else if (state == FIN)  busy_r <= 1'b0;
      if (state == FIN) begin
        res_hi_r <= hi_word;
        res_lo_r <= lo_word;
        ovf_r    <= (op_r == OP_DV) && ovf_pend;
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.ovf    = ovf_r;
  assign bus.res_hi = res_hi_r;
  assign bus.res_lo = res_lo_r;

endmodule

// File: tb/tb_agc_muldiv_unit.sv
// Scoreboard bench for agc_muldiv_unit: requests push model results, a
// monitor pops and compares on every done pulse.
module tb_agc_muldiv_unit;

  logic clk = 1'b0;
  logic reset_n;

  agc_muldiv_unit_if bus();

  agc_muldiv_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] hi;
    logic [14:0] lo;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Value of a ones' complement word's magnitude, arithmetically.
  function automatic int unsigned mag(input logic [14:0] w);
    return w[14] ? 32'h7FFF - 32'(w) : 32'(w);
  endfunction

  function automatic logic [14:0] enc(input bit s, input int unsigned m);
    return s ? 15'(32'h7FFF - m) : 15'(m);
  endfunction

  function automatic exp_t model(input bit op, input logic [14:0] a, input logic [14:0] l,
                                 input logic [14:0] b);
    exp_t e;
    int unsigned ma, ml, mb, p, d;
    bit s, sd;
    ma = mag(a);
    ml = mag(l);
    mb = mag(b);
    e.cyc = 0;
    if (!op) begin
      p     = ma * mb;
      s     = a[14] ^ b[14];
      e.hi  = enc(s, p / 16384);
      e.lo  = enc(s, p % 16384);
      e.ovf = 1'b0;
    end else begin
      sd = (ma == 0) ? l[14] : a[14];
      s  = sd ^ b[14];
      if (ma >= mb) begin
        e.ovf = 1'b1;
        e.hi  = enc(s, 16383);
        e.lo  = a;
      end else begin
        d     = ma * 16384 + ml;
        e.ovf = 1'b0;
        e.hi  = enc(s, d / mb);
        e.lo  = enc(sd, d % mb);
      end
    end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("ready_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail("done_timeout");
  endtask

  task automatic start_op(input bit op, input logic [14:0] a, input logic [14:0] l,
                          input logic [14:0] b);
    exp_t e;
    wait_ready();
    e = model(op, a, l, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.l_in  = l;
    bus.b_in  = b;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    sb.push_back(e);
    check("busy_after_accept", bus.busy, 1);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a_in  = 15'($urandom);
    bus.l_in  = 15'($urandom);
    bus.b_in  = 15'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done) begin
      dones++;
      if (sb.size() == 0) begin
        fail("unexpected_done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_hi", bus.res_hi, e.hi);
        check("res_lo", bus.res_lo, e.lo);
        check("ovf", bus.ovf, e.ovf);
        check("latency", cyc - e.cyc, 16);
        check("busy_at_done", bus.busy, 0);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.l_in  = '0;
    bus.b_in  = '0;
    reset_n   = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res_hi", bus.res_hi, 0);
    check("rst_res_lo", bus.res_lo, 0);
    check("rst_ovf", bus.ovf, 0);
    reset_n = 1'b1;

    // Directed cases.
    start_op(1'b0, 15'h0003, 15'h0000, 15'h0005);
    start_op(1'b0, 15'h7FFC, 15'h0000, 15'h0005);
    start_op(1'b0, 15'h3FFF, 15'h0000, 15'h3FFF);
    start_op(1'b1, 15'h0000, 15'h0064, 15'h0007);
    start_op(1'b1, 15'h7FFF, 15'h7F9B, 15'h0007);
    start_op(1'b1, 15'h0005, 15'h0000, 15'h0005);
    start_op(1'b1, 15'h0000, 15'h0000, 15'h0000);
    start_op(1'b1, 15'h7FFA, 15'h1234, 15'h7FFF);
    start_op(1'b0, 15'h0000, 15'h0000, 15'h7FF0);

    // Start presented in the done cycle is dropped.
    start_op(1'b0, 15'h1234, 15'h0000, 15'h0042);
    wait_done();
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 15'h0011;
    bus.b_in  = 15'h0022;
    @(negedge clk);
    check("start_in_done_ignored", bus.busy, 0);
    bus.start = 1'b0;

    // Start re-pulsed mid-iteration is dropped.
    d0 = dones;
    start_op(1'b1, 15'h0010, 15'h0100, 15'h0123);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 15'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready();
    repeat (2) @(negedge clk);
    check("single_done", dones - d0, 1);

    // Reset mid-iteration aborts with no done.
    start_op(1'b0, 15'h0ABC, 15'h0000, 15'h0123);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_res_hi", bus.res_hi, 0);
    check("abort_res_lo", bus.res_lo, 0);
    check("abort_ovf", bus.ovf, 0);
    void'(sb.pop_back());
    d0 = dones;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", dones - d0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit          op;
      int unsigned ma, mb;
      logic [14:0] a, l, b;
      op = 1'($urandom);
      mb = $urandom_range(0, 16383);
      if (op && (i % 5 != 0) && mb > 0) ma = $urandom_range(0, mb - 1);
      else                              ma = $urandom_range(0, 16383);
      if (i % 7 == 3) ma = 0;
      a = enc(1'($urandom), ma);
      b = enc(1'($urandom), mb);
      l = 15'($urandom);
      start_op(op, a, l, b);
    end

    wait_ready();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
